// File: rtl/muldiv_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : muldiv_if
// Brief    : Issue/complete handshake bundle between the EX stage and the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, select, data1, data2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, select, data1, data2,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : muldiv_unit
// Brief    : Fixed-latency RV32M multiply/divide unit. Radix-2 shift-add
//            multiply, restoring divide on magnitudes, sign fix-up on the
//            final iteration.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int                 c_cnt_w      = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_count = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_busy;
    logic               w_done;

    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_sel;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;

    // ---------------- operand capture ----------------
    logic             w_signed_a;
    logic             w_signed_b;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_capture;
    logic             w_last;

    // select[2]=divide; divide variants are signed unless select[0]; for
    // multiply only MULH (01) and MULHSU (10) treat DATA1 as signed.
    assign w_signed_a = bus.select[2] ? ~bus.select[0]
                                      : (bus.select[1:0] == 2'b01) || (bus.select[1:0] == 2'b10);
    assign w_signed_b = bus.select[2] ? ~bus.select[0]
                                      : (bus.select[1:0] == 2'b01);
    assign w_neg_a    = w_signed_a & bus.data1[WIDTH-1];
    assign w_neg_b    = w_signed_b & bus.data2[WIDTH-1];
    assign w_abs_a    = w_neg_a ? -bus.data1 : bus.data1;
    assign w_abs_b    = w_neg_b ? -bus.data2 : bus.data2;

    assign w_capture  = bus.start & ~bus.flush & (r_state != S_CALC);
    assign w_last     = (r_state == S_CALC) && (r_count == c_last_count);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_next = S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (bus.flush)   w_next = S_IDLE;
                else if (w_last) w_next = S_FIN;
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = w_capture ? S_CALC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- iteration datapath ----------------
    logic               w_is_div;
    logic [WIDTH:0]     w_mul_add;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res;

    assign w_is_div    = r_sel[2];
    // Multiply: {r_hi,r_lo} is the shifting product, r_lo[0] the multiplier bit.
    assign w_mul_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_b};
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

    assign w_hi_nx = w_is_div ? (w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0])
                              : w_mul_add[WIDTH:1];
    assign w_lo_nx = w_is_div ? {r_lo[WIDTH-2:0], w_div_ge}
                              : {w_mul_add[0], r_lo[WIDTH-1:1]};

    assign w_prod     = {w_hi_nx, w_lo_nx};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    // A zero divisor leaves an all-ones quotient that must not be negated.
    assign w_quo_fix  = ((r_neg_a ^ r_neg_b) && (r_b != '0)) ? -w_lo_nx : w_lo_nx;
    assign w_rem_fix  = r_neg_a ? -w_hi_nx : w_hi_nx;

    assign w_res = w_is_div ? (r_sel[1] ? w_rem_fix : w_quo_fix)
                            : ((r_sel[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0]
                                                     : w_prod_fix[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_sel    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_capture) begin
                r_sel   <= bus.select;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_hi    <= '0;
                r_lo    <= w_abs_a;
                r_b     <= w_abs_b;
                r_count <= '0;
            end else if (r_state == S_CALC) begin
                r_hi    <= w_hi_nx;
                r_lo    <= w_lo_nx;
                r_count <= r_count + c_cnt_w'(1);
            end
            if (w_last && !bus.flush) begin
                r_result <= w_res;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit with directed RV32M vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int WIDTH = 32;
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH)) bus ();
    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19] = '{
        '{OP_MULH,   32'd4,          32'hFFFFFFFF, 32'hFFFFFFFF},
        '{OP_MULHU,  32'd4,          32'hFFFFFFFF, 32'h00000003},
        '{OP_MULHSU, 32'd4,          32'hFFFFFFFF, 32'h00000003},
        '{OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF},
        '{OP_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001},
        '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
        '{OP_MULH,   32'hFFFFFFFD,   32'd5,        32'hFFFFFFFF},
        '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
        '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
        '{OP_DIVU,   32'd20,         32'd10,       32'd2},
        '{OP_REMU,   32'd7,          32'd0,        32'd7},
        '{OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF},
        '{OP_DIV,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF},
        '{OP_REM,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB},
        '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000},
        '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000},
        '{OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD},
        '{OP_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001},
        '{OP_REMU,   32'hFFFFFFFF,   32'd16,       32'h0000000F}
    };

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_exp = 0;
    logic [31:0] last_res = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got result %h at cycle %0d, expected none", bus.result, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("done_cycle", cyc, e.at);
                    last_res = e.res;
                end
            end
        end
    endtask

    // Drives START for one cycle, then scrambles operands to show they are not re-sampled.
    task automatic issue(logic [2:0] sel, logic [31:0] a, logic [31:0] b, logic [31:0] exp, bit track);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.select = sel;
        bus.data1  = a;
        bus.data2  = b;
        if (track) begin
            sb.push_back('{exp, cyc + 33});
            n_exp++;
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.data1  = $urandom;
        bus.data2  = $urandom;
        bus.select = 3'($urandom);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk); #1;
            i++;
        end
        chk("pending_after_wait", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic [31:0] prev;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.select = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_result", bus.result, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MUL 10*20 with cycle-accurate BUSY/DONE profile
        issue(OP_MUL, 32'd10, 32'd20, 32'd200, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk($sformatf("busy_c+%0d", k), bus.busy, (k <= 32) ? 1 : 0);
            chk($sformatf("done_c+%0d", k), bus.done, (k == 33) ? 1 : 0);
        end
        drain();

        foreach (vecs[i]) begin
            issue(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            drain();
        end

        // START pulsed at c+5 while busy must be dropped
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.select = OP_DIVU; bus.data1 = 32'd100; bus.data2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // START held in the FIN cycle issues back-to-back
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        repeat (32) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.select = OP_REM; bus.data1 = 32'd100; bus.data2 = 32'd7;
        sb.push_back('{32'd2, cyc + 33});
        n_exp++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();

        // FLUSH at c+10: no DONE, RESULT retained
        prev = last_res;
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", bus.done, 0);
        chk("flush_result", bus.result, prev);
        repeat (40) @(negedge clk);
        chk("flush_result_later", bus.result, prev);

        // Asynchronous RESET mid-operation at c+20
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
        chk("async_rst_result", bus.result, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        chk("done_count", n_done, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
